// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned imem requests, buffers in-order
// responses in a small FIFO for decode, and squashes stale fetches on redirect.
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus_four,
  output logic [XLEN-1:0] if_instr,
  output logic [3:0]      buf_count
);

  localparam int              PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [3:0]      DEPTH_C  = 4'(BUF_DEPTH);
  localparam logic [XLEN-1:0] FOUR     = XLEN'(4);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [3:0]       outst_q, outst_d;
  logic [3:0]       drop_q, drop_d;
  logic [3:0]       count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [XLEN-1:0]  fifo_pc_q    [BUF_DEPTH];
  logic [XLEN-1:0]  fifo_instr_q [BUF_DEPTH];

  logic            req_fire;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_target;
  logic            unused_redirect_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Capacity counts in-flight requests too, so every response has a free slot.
  assign imem_req_valid = rst && !redirect_valid && ((count_q + outst_q) < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign if_valid        = rst && !redirect_valid && (count_q != 4'd0);
  assign if_pc           = fifo_pc_q[head_q];
  assign if_pc_plus_four = fifo_pc_q[head_q] + FOUR;
  assign if_instr        = fifo_instr_q[head_q];
  assign buf_count       = count_q;

  assign push = rst && !redirect_valid && imem_rsp_valid && (drop_q == 4'd0);
  assign pop  = if_valid && id_ready;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    count_d  = count_q;
    head_d   = head_q;
    tail_d   = tail_q;
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      pc_d     = redirect_target;
      rsp_pc_d = redirect_target;
      outst_d  = outst_q - {3'b000, imem_rsp_valid};
      drop_d   = outst_d;
      count_d  = '0;
      head_d   = '0;
      tail_d   = '0;
    end else begin
      if (req_fire) pc_d = pc_q + FOUR;
      outst_d = outst_q + {3'b000, req_fire} - {3'b000, imem_rsp_valid};
      if (imem_rsp_valid && (drop_q != 4'd0)) drop_d = drop_q - 4'd1;
      if (push) begin
        rsp_pc_d = rsp_pc_q + FOUR;
        tail_d   = ptr_inc(tail_q);
      end
      if (pop) head_d = ptr_inc(head_q);
      count_d = count_q + {3'b000, push} - {3'b000, pop};
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[tail_q]    <= rsp_pc_q;
      fifo_instr_q[tail_q] <= imem_rsp_data;
    end
  end

  push_into_full_a : assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (count_q == DEPTH_C)));

endmodule
